// File: rtl/kgp_mem_pkg.sv
// Shared definitions for the KGP data-memory responder: FSM encoding,
// datapath widths and the access error check.
package kgp_mem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Full-width word-index compare so high address bits never alias onto RAM.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input logic [WORD_W-3:0] depth);
    return (addr[1:0] != 2'b00) || (addr[WORD_W-1:2] >= depth);
  endfunction

endpackage

// File: rtl/kgp_dmem_responder_if.sv
// Load/store request and response channel between the core's memory
// stage (master) and the data-memory responder (slave).
interface kgp_dmem_if
  import kgp_mem_pkg::*;
();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/kgp_sram_1p.sv
// Single-port word RAM, synchronous write and synchronous read.
// Contents are not reset.
module kgp_sram_1p
  import kgp_mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WORD_W-1:0]        wdata_i,
  output logic [WORD_W-1:0]        rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/kgp_dmem_responder.sv
// Target end of the KGP core's load/store interface: one request at a time,
// WAIT_CYCLES wait states, then a held response with load data or error.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// WAIT    | counting down wait states, inputs ignored
// RESP    | access done on entry, response held until rsp_ready
module kgp_dmem_responder
  import kgp_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  kgp_dmem_if.slave dmem
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic              req_ready_q, rsp_valid_q, rsp_err_q, rsp_load_q;

  logic              accept, enter_resp, rsp_done;
  logic              acc_we, acc_err;
  logic [WORD_W-1:0] acc_addr, acc_wdata;
  logic [WORD_W-1:0] ram_rdata;

  assign accept   = (state_q == ST_IDLE) && dmem.req_valid && req_ready_q;
  assign rsp_done = (state_q == ST_RESP) && dmem.rsp_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        cnt_d   = CNT_W'(WAIT_CYCLES);
        state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: if (dmem.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accept edge, before the
  // capture registers load, so the access takes the live request instead.
  assign acc_we     = (state_q == ST_IDLE) ? dmem.req_we    : we_q;
  assign acc_addr   = (state_q == ST_IDLE) ? dmem.req_addr  : addr_q;
  assign acc_wdata  = (state_q == ST_IDLE) ? dmem.req_wdata : wdata_q;
  assign acc_err    = addr_err(acc_addr, (WORD_W-2)'(DEPTH));
  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

  kgp_sram_1p #(.DEPTH(DEPTH)) u_sram (
    .clk     (clk),
    .en_i    (enter_resp && !acc_err),
    .we_i    (acc_we),
    .addr_i  (acc_addr[AW+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      if (accept) begin
        we_q    <= dmem.req_we;
        addr_q  <= dmem.req_addr;
        wdata_q <= dmem.req_wdata;
      end
      if (enter_resp) begin
        rsp_err_q  <= acc_err;
        rsp_load_q <= !acc_err && !acc_we;
      end else if (rsp_done) begin
        rsp_err_q  <= 1'b0;
        rsp_load_q <= 1'b0;
      end
    end
  end

  // RAM read register only changes on RESP entry, so gating it with the
  // registered load flag keeps rsp_rdata stable and zero outside loads.
  assign dmem.req_ready = req_ready_q;
  assign dmem.rsp_valid = rsp_valid_q;
  assign dmem.rsp_err   = rsp_err_q;
  assign dmem.rsp_rdata = rsp_load_q ? ram_rdata : '0;

endmodule

// File: tb/tb_kgp_dmem_responder.sv
// Bench for kgp_dmem_responder: two instances (2 and 0 wait states), directed
// scenarios then random traffic against a word-array memory model.
module tb_kgp_dmem_responder;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kgp_dmem_if if_w2();
  kgp_dmem_if if_w0();

  kgp_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .dmem(if_w2.slave));
  kgp_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n), .dmem(if_w0.slave));

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_w2 [int];
  logic [31:0] mem_w0 [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_ready(input int sel);
    return (sel == 0) ? {31'b0, if_w2.req_ready} : {31'b0, if_w0.req_ready};
  endfunction
  function automatic logic [31:0] get_valid(input int sel);
    return (sel == 0) ? {31'b0, if_w2.rsp_valid} : {31'b0, if_w0.rsp_valid};
  endfunction
  function automatic logic [31:0] get_err(input int sel);
    return (sel == 0) ? {31'b0, if_w2.rsp_err} : {31'b0, if_w0.rsp_err};
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? if_w2.rsp_rdata : if_w0.rsp_rdata;
  endfunction

  task automatic drive(input int sel, input bit v, input bit we,
                       input logic [31:0] a, input logic [31:0] d, input bit rr);
    if (sel == 0) begin
      if_w2.req_valid = v; if_w2.req_we = we; if_w2.req_addr = a;
      if_w2.req_wdata = d; if_w2.rsp_ready = rr;
    end else begin
      if_w0.req_valid = v; if_w0.req_we = we; if_w0.req_addr = a;
      if_w0.req_wdata = d; if_w0.rsp_ready = rr;
    end
  endtask

  function automatic bit mdl_err(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  // One full transaction: issue, measure latency, optionally hold off the
  // response, then handshake and check the channel returns to idle.
  task automatic txn(input int sel, input bit we, input logic [31:0] a,
                     input logic [31:0] d, input int hold, input bit early);
    int n;
    int idx;
    int w;
    bit known;
    bit exp_e;
    logic [31:0] exp_d;
    logic [31:0] r0;
    w = (sel == 0) ? 2 : 0;
    @(negedge clk);
    drive(sel, 1'b1, we, a, d, early);
    n = 0;
    while (get_ready(sel) != 32'd1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_seen", get_ready(sel), 32'd1);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, early);
    chk("req_ready_low_after_accept", get_ready(sel), 32'd0);
    n = 1;
    while (get_valid(sel) != 32'd1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", 32'(n), 32'(w + 1));

    exp_e = mdl_err(a);
    idx = int'(a / 4);
    known = 1'b1;
    exp_d = 32'h0;
    if (!exp_e) begin
      if (we) begin
        if (sel == 0) mem_w2[idx] = d; else mem_w0[idx] = d;
      end else if (sel == 0 && mem_w2.exists(idx)) exp_d = mem_w2[idx];
      else if (sel != 0 && mem_w0.exists(idx)) exp_d = mem_w0[idx];
      else known = 1'b0;
    end
    chk("rsp_err", get_err(sel), {31'b0, exp_e});
    if (known) chk("rsp_rdata", get_rdata(sel), exp_d);
    r0 = get_rdata(sel);

    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_rsp_valid", get_valid(sel), 32'd1);
        chk("hold_rsp_rdata", get_rdata(sel), r0);
        chk("hold_req_ready", get_ready(sel), 32'd0);
      end
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    end
    @(negedge clk);
    chk("post_rsp_valid", get_valid(sel), 32'd0);
    chk("post_rsp_rdata", get_rdata(sel), 32'd0);
    chk("post_rsp_err", get_err(sel), 32'd0);
    chk("post_req_ready", get_ready(sel), 32'd1);
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    int sel;
    int r;
    bit we;
    bit early;
    logic [31:0] a;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_rsp_valid", get_valid(s), 32'd0);
      chk("reset_rsp_rdata", get_rdata(s), 32'd0);
      chk("reset_rsp_err", get_err(s), 32'd0);
      chk("reset_req_ready", get_ready(s), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_reset_w2", get_ready(0), 32'd1);
    chk("req_ready_after_reset_w0", get_ready(1), 32'd1);

    // Basic store/load, misalignment, out of range and aliasing
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    txn(0, 1'b0, 32'h13, 32'h0, 0, 1'b0);
    txn(0, 1'b1, 32'h12, 32'h12345678, 0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    txn(0, 1'b1, 32'h0, 32'hCAFE0000, 0, 1'b0);
    txn(0, 1'b1, 32'h1000, 32'hBAD00001, 0, 1'b0);
    txn(0, 1'b1, 32'h1000_0000, 32'hBAD00002, 0, 1'b0);
    txn(0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    txn(0, 1'b1, 32'(DEPTH * 4 - 4), 32'h0A0A0A0A, 0, 1'b0);
    txn(0, 1'b0, 32'(DEPTH * 4 - 4), 32'h0, 0, 1'b0);
    txn(0, 1'b0, 32'(DEPTH * 4), 32'h0, 0, 1'b0);
    // Backpressure, and rsp_ready held high ahead of the response
    txn(0, 1'b0, 32'h10, 32'h0, 5, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b1);

    // Zero wait states, back-to-back stores with rsp_ready tied high
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h0, 32'h1, 1'b1);
    chk("zw_ready_0", get_ready(1), 32'd1);
    @(negedge clk);
    chk("zw_valid_1", get_valid(1), 32'd1);
    chk("zw_ready_1", get_ready(1), 32'd0);
    chk("zw_store_rdata", get_rdata(1), 32'd0);
    drive(1, 1'b1, 1'b1, 32'h4, 32'h2, 1'b1);
    @(negedge clk);
    chk("zw_valid_2", get_valid(1), 32'd0);
    chk("zw_ready_2", get_ready(1), 32'd1);
    @(negedge clk);
    chk("zw_valid_3", get_valid(1), 32'd1);
    chk("zw_ready_3", get_ready(1), 32'd0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("zw_valid_4", get_valid(1), 32'd0);
    chk("zw_ready_4", get_ready(1), 32'd1);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    mem_w0[0] = 32'h1;
    mem_w0[1] = 32'h2;
    txn(1, 1'b0, 32'h0, 32'h0, 0, 1'b1);
    txn(1, 1'b0, 32'h4, 32'h0, 0, 1'b1);

    // Async reset while a store sits in WAIT: the store must be dropped
    txn(0, 1'b1, 32'h8, 32'h11, 0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h8, 32'h55, 1'b0);
    chk("rst_wait_ready_idle", get_ready(0), 32'd1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst_wait_in_wait", get_ready(0), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", get_valid(0), 32'd0);
    chk("rst_mid_req_ready", get_ready(0), 32'd0);
    chk("rst_mid_rsp_err", get_err(0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready_after", get_ready(0), 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_phantom_rsp", get_valid(0), 32'd0);
    txn(0, 1'b0, 32'h8, 32'h0, 0, 1'b0);

    // Random traffic on both instances against the model
    for (int k = 0; k < 80; k++) begin
      sel = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 6)       a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      else if (r < 8)  a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      else if (r == 8) a = $urandom | 32'h0000_1000;
      else             a = ($urandom_range(0, 1) == 0) ? 32'(DEPTH * 4 - 4) : 32'(DEPTH * 4);
      we = 1'($urandom_range(0, 1));
      early = ($urandom_range(0, 3) == 0);
      txn(sel, we, a, $urandom, int'($urandom_range(0, 3)), early);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
